// File: rtl/logic_unit_pipe.sv
// ============================================================================
// logic_unit_pipe : eight-function bitwise logic unit with XOR accumulator and
//                   a registered D-entry output FIFO behind valid/ready.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module logic_unit_pipe #(
  parameter int N = 4,
  parameter int D = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             c,
  output logic [$clog2(D+1)-1:0]   count
);

  localparam int c_PW = $clog2(D);
  localparam int c_CW = $clog2(D+1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(D);
  localparam logic [2:0]      c_OP_ACC = 3'd7;

  logic [N-1:0]    r_mem [D];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [N-1:0]    r_acc;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [N-1:0]    w_acc_base;
  logic [N-1:0]    w_result;

  // Handshake status comes only from the registered count, so out_ready
  // never reaches in_ready combinationally.
  assign w_full   = (r_count == c_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && !w_full;
  assign w_pop    = out_ready && !w_empty;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign c         = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;

  always_comb begin
    w_acc_base = acc_clr ? '0 : r_acc;
    w_result   = '0;
    case (op)
      3'd0: w_result = a & b;
      3'd1: w_result = a | b;
      3'd2: w_result = a ^ b;
      3'd3: w_result = ~(a & b);
      3'd4: w_result = ~(a | b);
      3'd5: w_result = ~(a ^ b);
      3'd6: w_result = a & ~b;
      3'd7: w_result = w_acc_base ^ (a & b);
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_acc    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && (op == c_OP_ACC)) r_acc <= w_result;
      else if (acc_clr)               r_acc <= '0;
    end
  end

  // Storage needs no reset: stale entries are masked by c=0 when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_result;
  end

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
// ============================================================================
// tb_logic_unit_pipe : directed and randomized self-checking bench.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_logic_unit_pipe;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'd0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  c;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] mq[$];
  logic [N-1:0] macc = '0;

  logic_unit_pipe #(.N(N), .D(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_op(input logic [2:0] f, input logic [N-1:0] x,
                                          input logic [N-1:0] y, input logic [N-1:0] base);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (f)
        3'd0: r[i] = x[i] & y[i];
        3'd1: r[i] = x[i] | y[i];
        3'd2: r[i] = x[i] ^ y[i];
        3'd3: r[i] = !(x[i] & y[i]);
        3'd4: r[i] = !(x[i] | y[i]);
        3'd5: r[i] = (x[i] == y[i]);
        3'd6: r[i] = x[i] & !y[i];
        default: r[i] = base[i] ^ (x[i] & y[i]);
      endcase
    end
    return r;
  endfunction

  // Reference model: queue of pending results plus the accumulator value.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      macc = '0;
    end else begin
      logic         take, give;
      logic [N-1:0] base, res;
      take = in_valid && (mq.size() < D);
      give = out_ready && (mq.size() > 0);
      base = acc_clr ? '0 : macc;
      res  = ref_op(op, a, b, base);
      if (give) void'(mq.pop_front());
      if (take) mq.push_back(res);
      if (take && op == 3'd7) macc = res;
      else if (acc_clr)       macc = '0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(in_ready),  32'(mq.size() < D));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("count",     32'(count),     32'(mq.size()));
    chk("c",         32'(c),         (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [2:0] f, input logic [N-1:0] x,
                      input logic [N-1:0] y, input logic clr, input logic rdy);
    in_valid = v; op = f; a = x; b = y; acc_clr = clr; out_ready = rdy;
  endtask

  logic [N-1:0] ops_exp [7];
  logic [N-1:0] acc_b   [3];
  logic [N-1:0] acc_exp [3];

  initial begin
    ops_exp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0100};
    acc_b   = '{4'b0011, 4'b0110, 4'b0001};
    acc_exp = '{4'b0011, 4'b0101, 4'b0100};

    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Empty pops never underflow.
    beat(1'b0, 3'd0, 4'h0, 4'h0, 1'b0, 1'b1);
    repeat (3) step();
    chk("empty_count", 32'(count), 32'd0);
    chk("empty_c",     32'(c),     32'd0);

    for (int i = 0; i < 7; i++) begin
      beat(1'b1, 3'(i), 4'b1100, 4'b1010, 1'b0, 1'b1);
      step();
      chk("allops_c", 32'(c), 32'(ops_exp[i]));
    end

    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 3'd7, 4'b1111, acc_b[i], 1'b0, 1'b1);
      step();
      chk("acc_c", 32'(c), 32'(acc_exp[i]));
    end
    beat(1'b1, 3'd7, 4'b1111, 4'b1000, 1'b1, 1'b1);
    step();
    chk("acc_clr_beat", 32'(c), 32'b1000);
    beat(1'b0, 3'd7, 4'b0000, 4'b0000, 1'b1, 1'b1);
    step();
    beat(1'b1, 3'd7, 4'b1111, 4'b0001, 1'b0, 1'b1);
    step();
    chk("acc_after_clr", 32'(c), 32'b0001);
    beat(1'b0, 3'd0, 4'h0, 4'h0, 1'b0, 1'b1);
    step();

    // Backpressure: two accepted, third waits for space.
    beat(1'b1, 3'd0, 4'b1111, 4'b0001, 1'b0, 1'b0); step();
    beat(1'b1, 3'd0, 4'b1111, 4'b0010, 1'b0, 1'b0); step();
    beat(1'b1, 3'd0, 4'b1111, 4'b0100, 1'b0, 1'b0); step();
    chk("full_count",    32'(count),    32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_c_hold",   32'(c),        32'b0001);
    out_ready = 1'b1; step();
    chk("pop_only_count", 32'(count),    32'd1);
    chk("pop_in_ready",   32'(in_ready), 32'd1);
    out_ready = 1'b0; step();
    chk("third_accepted", 32'(count), 32'd2);
    chk("third_head",     32'(c),     32'b0010);
    beat(1'b0, 3'd0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(); step();

    // Simultaneous push/pop across pointer wrap.
    beat(1'b1, 3'd2, 4'h5, 4'h3, 1'b0, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 3'd1, 4'(i), 4'(i << 1), 1'b0, 1'b1);
      step();
      chk("wrap_count", 32'(count), 32'd1);
    end
    beat(1'b0, 3'd0, 4'h0, 4'h0, 1'b0, 1'b1);
    step();

    // Asynchronous reset with results queued.
    beat(1'b1, 3'd1, 4'h3, 4'h4, 1'b0, 1'b0); step(); step();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_c",         32'(c),         32'd0);
    chk("arst_count",     32'(count),     32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    beat(1'b0, 3'd0, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    beat(1'b1, 3'd0, 4'b1111, 4'b1010, 1'b0, 1'b1);
    step();
    chk("post_rst_c", 32'(c), 32'b1010);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      beat(1'($urandom_range(0, 3) != 0), 3'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    beat(1'b0, 3'd0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
